// File: rtl/load_store_unit.sv
// Load/store unit: one memory transaction at a time between the core and a
// req/ack memory port. Handles lane placement for stores, lane extraction and
// sign/zero extension for loads, alignment checks and an ack timeout.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        LSU_Start,
    input  logic        LSU_Write,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALU_Output,
    input  logic [31:0] READ_Data_2,
    output logic        MEM_Req,
    output logic [31:0] MEM_Addr,
    output logic        MEM_WE,
    output logic [3:0]  MEM_BE,
    output logic [31:0] MEM_WData,
    input  logic        MEM_Ack,
    input  logic [31:0] MEM_RData,
    output logic        LSU_Busy,
    output logic        LSU_Done,
    output logic [31:0] LOAD_Data,
    output logic        LSU_Error
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        write_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        req_q, we_q, done_q, err_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q, wdata_q, load_q;

    logic        legal_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] lane_d;
    logic [31:0] load_d;

    // Decode the incoming request: legality, byte enables, lane-replicated store data
    always_comb begin
        legal_d = 1'b1;
        be_d    = 4'b1111;
        wdata_d = READ_Data_2;
        case (Funct3)
            3'b000, 3'b100: begin
                be_d    = 4'b0001 << ALU_Output[1:0];
                wdata_d = {4{READ_Data_2[7:0]}};
                legal_d = !(LSU_Write && Funct3[2]);
            end
            3'b001, 3'b101: begin
                be_d    = 4'b0011 << ALU_Output[1:0];
                wdata_d = {2{READ_Data_2[15:0]}};
                legal_d = !ALU_Output[0] && !(LSU_Write && Funct3[2]);
            end
            3'b010: begin
                be_d    = 4'b1111;
                legal_d = (ALU_Output[1:0] == 2'b00);
            end
            default: legal_d = 1'b0;
        endcase
    end

    // Pull the addressed lane down to bit 0 and extend it per access type
    always_comb begin
        lane_d = MEM_RData >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_d = {{24{lane_d[7]}}, lane_d[7:0]};
            3'b100:  load_d = {24'h0, lane_d[7:0]};
            3'b001:  load_d = {{16{lane_d[15]}}, lane_d[15:0]};
            3'b101:  load_d = {16'h0, lane_d[15:0]};
            default: load_d = lane_d;
        endcase
    end

    // Transaction FSM with all memory-side and core-side outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            write_q <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            be_q    <= 4'b0000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            load_q  <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (LSU_Start) begin
                        write_q <= LSU_Write;
                        f3_q    <= Funct3;
                        off_q   <= ALU_Output[1:0];
                        if (legal_d) begin
                            state_q <= ACCESS;
                            cnt_q   <= 8'd0;
                            req_q   <= 1'b1;
                            we_q    <= LSU_Write;
                            be_q    <= be_d;
                            addr_q  <= {ALU_Output[31:2], 2'b00};
                            wdata_q <= wdata_d;
                        end else begin
                            // Rejected requests never reach the memory port
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (MEM_Ack) begin
                        state_q <= DONE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b0;
                        if (!write_q) load_q <= load_d;
                    end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                        // Last allowed wait cycle passed without an ack
                        state_q <= DONE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign MEM_Req   = req_q;
    assign MEM_Addr  = addr_q;
    assign MEM_WE    = we_q;
    assign MEM_BE    = be_q;
    assign MEM_WData = wdata_q;
    assign LSU_Busy  = (state_q != IDLE);
    assign LSU_Done  = done_q;
    assign LSU_Error = err_q;
    assign LOAD_Data = load_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 16, max cycles ACCESS waits for MEM_Ack before aborting (range 2..255).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-high.
REQ-004 LSU_Start  in  1  request valid; sampled only in IDLE.
REQ-005 LSU_Write  in  1  1 = store, 0 = load; sampled with LSU_Start.
REQ-006 Funct3  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
REQ-007 ALU_Output  in  32  effective byte address from ALU.
REQ-008 READ_Data_2  in  32  store data, right-aligned.
REQ-009 MEM_Req  out  1  memory request, held until acknowledged.
REQ-010 MEM_Addr  out  32  word address: {captured_addr[31:2], 2'b00}.
REQ-011 MEM_WE  out  1  write enable for current request.
REQ-012 MEM_BE  out  4  byte enables, bit i = byte lane i (little-endian).
REQ-013 MEM_WData  out  32  store data shifted to lane position.
REQ-014 MEM_Ack  in  1  memory completion; valid only while MEM_Req=1.
REQ-015 MEM_RData  in  32  read word; valid in the cycle MEM_Ack=1 on a load.
REQ-016 LSU_Busy  out  1  high whenever state != IDLE; core stalls on it.
REQ-017 LSU_Done  out  1  one-cycle completion pulse.
REQ-018 LOAD_Data  out  32  aligned, extended load result.
REQ-019 LSU_Error  out  1  qualifies LSU_Done: misaligned, illegal Funct3, or timeout.

Function
REQ-020 FSM states IDLE, ACCESS, DONE; transitions only on rising clk edge.
REQ-021 IDLE + LSU_Start=1: capture LSU_Write, Funct3, ALU_Output, READ_Data_2; legal -> ACCESS; illegal -> DONE with LSU_Error=1, no MEM_Req.
REQ-022 Illegal: H/HU with addr[0]=1; W with addr[1:0]!=00; Funct3 011,110,111; store with Funct3 100 or 101.
REQ-023 LSU_Start outside IDLE is ignored; no queuing.
REQ-024 ACCESS: MEM_Req=1 with stable MEM_Addr/WE/BE/WData every cycle until MEM_Ack=1, then -> DONE.
REQ-025 Cycle counter cleared on ACCESS entry; counter reaching TIMEOUT_CYCLES without Ack -> DONE with LSU_Error=1, MEM_Req deasserted; LOAD_Data unchanged.
REQ-026 DONE lasts exactly one cycle with LSU_Done=1, then IDLE; a new Start is accepted in the following IDLE cycle.
REQ-027 Latency: Start in cycle N, Ack in first ACCESS cycle -> MEM_Req in N+1, LSU_Done in N+2; each extra wait cycle adds one.
REQ-028 MEM_BE: B -> 1<<addr[1:0]; H -> 4'b0011<<addr[1:0]; W -> 4'b1111; loads drive the same BE.
REQ-029 MEM_WData: B -> byte replicated on all 4 lanes; H -> halfword on both halves; W -> unchanged.
REQ-030 Load: select lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W pass-through; register into LOAD_Data on the Ack cycle.
REQ-031 LOAD_Data holds its value until the next successful load; stores and errors leave it unchanged.
REQ-032 MEM_Req, MEM_WE, LSU_Done are 0 in IDLE; MEM_WE=0 for loads throughout.

Reset
REQ-033 rst=1 immediately forces IDLE; MEM_Req, MEM_WE, MEM_BE, MEM_WData, MEM_Addr, LSU_Done, LSU_Error, LOAD_Data = 0, counter = 0.
REQ-034 rst mid-ACCESS abandons the transaction without a Done pulse; a late MEM_Ack after reset is ignored.
REQ-035 First Start is accepted on the first rising edge after rst deasserts.

Verification
REQ-036 LW addr 0x100, Ack in the first ACCESS cycle, RData 0xDEADBEEF -> Done at N+2, LOAD_Data=0xDEADBEEF, LSU_Error=0.
REQ-037 LB addr 0x103, RData 0x80FF_0000 -> BE=1000, LOAD_Data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-038 SH addr 0x202, data 0x1234ABCD -> MEM_WE=1, BE=1100, WData=0xABCDABCD, MEM_Addr=0x200.
REQ-039 LW addr 0x101 -> no MEM_Req, Done with LSU_Error=1 at N+1, LOAD_Data unchanged.
REQ-040 LW with Ack withheld -> MEM_Req high 16 cycles, then Done+Error; Start pulses during Busy ignored.
REQ-041 rst asserted on the 3rd wait cycle of a store -> MEM_Req low at once, no Done; subsequent LW completes normally.
